// File: rtl/golden_chk_pkg.sv
// golden_chk_pkg
// Shared helpers for the golden stream checker:
//   lvl_width : width of the FIFO occupancy count for a given depth
//               (one extra bit so that "full" is representable)
//   ch_lsb    : LSB position of channel c inside a packed NUM_CH*W bus
package golden_chk_pkg;

  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ch_lsb(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/golden_chk_fifo.sv
// golden_chk_fifo
// Golden-entry FIFO: stores golden data and mask side by side, tracks
// occupancy, and works out the per-cycle handshake with the DUT side.
//
// Ports:
//   clk           in   clock
//   rst           in   synchronous flush (reset or soft clear)
//   push_req      in   golden entry offered
//   pop_req       in   DUT result present
//   wr_data       in   DW  golden data to store
//   wr_mask       in   DW  golden mask to store
//   rd_data       out  DW  head-of-FIFO golden data
//   rd_mask       out  DW  head-of-FIFO golden mask
//   level         out  LW  occupancy
//   bypass        out  pop on empty FIFO served by the same-cycle push
//   do_pop        out  head entry is consumed this cycle
//   overflow_evt  out  push dropped: full and no same-cycle pop
//   underflow_evt out  pop request with empty FIFO and nothing to bypass
module golden_chk_fifo
  import golden_chk_pkg::*;
#(
  parameter int DW    = 192,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_req,
  input  logic                    pop_req,
  input  logic [DW-1:0]           wr_data,
  input  logic [DW-1:0]           wr_mask,
  output logic [DW-1:0]           rd_data,
  output logic [DW-1:0]           rd_mask,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    bypass,
  output logic                    do_pop,
  output logic                    overflow_evt,
  output logic                    underflow_evt
);

  localparam int LW = lvl_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] data_mem [DEPTH];
  logic [DW-1:0] mask_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // A bypassed golden entry is consumed directly and never stored.
  assign bypass        = pop_req & empty & push_req;
  assign do_pop        = pop_req & ~empty;
  assign do_push       = push_req & ~bypass & (~full | do_pop);
  assign overflow_evt  = push_req & full & ~do_pop;
  assign underflow_evt = pop_req & empty & ~push_req;

  assign rd_data = data_mem[rd_ptr];
  assign rd_mask = mask_mem[rd_ptr];

  // Storage is not reset; occupancy alone defines which entries are live.
  // On push+pop while full, wr_ptr == rd_ptr: the head is read before the
  // write lands, so the pair is consistent.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_mem[wr_ptr] <= wr_data;
      mask_mem[wr_ptr] <= wr_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/golden_stream_checker.sv
// golden_stream_checker
// Multi-channel golden-value scoreboard. Golden entries are queued in a
// FIFO so the DUT may answer with any latency; each DUT result pops one
// entry and is compared per channel under a per-bit mask. Results,
// statistics, sticky flags and the first-failure snapshot are registered
// one cycle after the DUT result.
//
// Ports:
//   clk, rst          in   clock, synchronous active-high reset
//   clear             in   soft clear, same effect as rst
//   ch_en             in   NUM_CH per-channel compare enable
//   gold_valid        in   push golden entry
//   gold_data/mask    in   NUM_CH*W golden value / must-match mask
//   dut_valid         in   DUT result present
//   dut_data          in   NUM_CH*W DUT value
//   mism              out  mismatch pulse for the last compare
//   fail              out  sticky mismatch or protocol error
//   fail_ch           out  NUM_CH sticky per-channel mismatch
//   underflow         out  sticky DUT result with nothing to compare
//   overflow          out  sticky golden entry dropped on full FIFO
//   cmp_cnt/mism_cnt  out  CNT_W saturating compare / mismatch counts
//   ff_valid          out  first-failure snapshot valid
//   ff_cycle          out  CNT_W cycle index of first failure
//   ff_ch             out  NUM_CH failing channels (0 on protocol error)
//   ff_dut/ff_gold    out  NUM_CH*W data at first failure
//   level             out  FIFO occupancy
module golden_stream_checker
  import golden_chk_pkg::*;
#(
  parameter int NUM_CH       = 6,
  parameter int W            = 32,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    gold_valid,
  input  logic [NUM_CH*W-1:0]     gold_data,
  input  logic [NUM_CH*W-1:0]     gold_mask,
  input  logic                    dut_valid,
  input  logic [NUM_CH*W-1:0]     dut_data,
  output logic                    mism,
  output logic                    fail,
  output logic [NUM_CH-1:0]       fail_ch,
  output logic                    underflow,
  output logic                    overflow,
  output logic [CNT_W-1:0]        cmp_cnt,
  output logic [CNT_W-1:0]        mism_cnt,
  output logic                    ff_valid,
  output logic [CNT_W-1:0]        ff_cycle,
  output logic [NUM_CH-1:0]       ff_ch,
  output logic [NUM_CH*W-1:0]     ff_dut,
  output logic [NUM_CH*W-1:0]     ff_gold,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int DW = NUM_CH * W;

  logic              flush;
  logic [DW-1:0]     rd_data;
  logic [DW-1:0]     rd_mask;
  logic              bypass;
  logic              do_pop;
  logic              overflow_evt;
  logic              underflow_evt;
  logic [DW-1:0]     cmp_gold;
  logic [DW-1:0]     cmp_mask;
  logic [NUM_CH-1:0] miss;
  logic              stopped;
  logic              cmp_evt;
  logic              mism_evt;
  logic              proto_evt;
  logic [CNT_W-1:0]  cycle_cnt;

  assign flush = rst | clear;

  golden_chk_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (flush),
    .push_req      (gold_valid),
    .pop_req       (dut_valid),
    .wr_data       (gold_data),
    .wr_mask       (gold_mask),
    .rd_data       (rd_data),
    .rd_mask       (rd_mask),
    .level         (level),
    .bypass        (bypass),
    .do_pop        (do_pop),
    .overflow_evt  (overflow_evt),
    .underflow_evt (underflow_evt)
  );

  assign cmp_gold = bypass ? gold_data : rd_data;
  assign cmp_mask = bypass ? gold_mask : rd_mask;

  always_comb begin
    miss = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      miss[c] = ch_en[c] &
                (|((dut_data[ch_lsb(c, W) +: W] ^ cmp_gold[ch_lsb(c, W) +: W])
                   & cmp_mask[ch_lsb(c, W) +: W]));
    end
  end

  // fail is registered, so the compare that raised it still counts and
  // only later ones are suppressed; the FIFO keeps draining regardless.
  assign stopped   = (STOP_ON_FAIL != 0) & fail;
  assign cmp_evt   = (do_pop | bypass) & ~stopped;
  assign mism_evt  = cmp_evt & (|miss);
  assign proto_evt = overflow_evt | underflow_evt;

  always_ff @(posedge clk) begin
    if (flush) begin
      cycle_cnt <= '0;
    end else if (cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      mism      <= 1'b0;
      fail      <= 1'b0;
      fail_ch   <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      cmp_cnt   <= '0;
      mism_cnt  <= '0;
    end else begin
      mism <= mism_evt;
      if (cmp_evt && cmp_cnt != '1)   cmp_cnt  <= cmp_cnt + CNT_W'(1);
      if (mism_evt && mism_cnt != '1) mism_cnt <= mism_cnt + CNT_W'(1);
      if (mism_evt)      fail_ch   <= fail_ch | miss;
      if (underflow_evt) underflow <= 1'b1;
      if (overflow_evt)  overflow  <= 1'b1;
      if (mism_evt || proto_evt) fail <= 1'b1;
    end
  end

  // Protocol errors take the snapshot too, with no failing channel and the
  // raw inputs of that cycle as the data.
  always_ff @(posedge clk) begin
    if (flush) begin
      ff_valid <= 1'b0;
      ff_cycle <= '0;
      ff_ch    <= '0;
      ff_dut   <= '0;
      ff_gold  <= '0;
    end else if (!ff_valid && (mism_evt || proto_evt)) begin
      ff_valid <= 1'b1;
      ff_cycle <= cycle_cnt;
      ff_ch    <= mism_evt ? miss : '0;
      ff_dut   <= dut_data;
      ff_gold  <= mism_evt ? cmp_gold : gold_data;
    end
  end

endmodule

// File: doc/golden_stream_checker.md
Name: golden_stream_checker

Overview:
- Parametrised, synthesizable scoreboard for checking DUT outputs against golden values in dynamic simulation and emulation.
- Generalises the per-signal, same-cycle golden-compare checker to NUM_CH channels of up to W bits.
- Golden values are buffered in a FIFO, so the DUT may respond with arbitrary latency.
- Adds per-bit don't-care masks, saturating statistics, sticky per-channel fail flags and first-failure capture; bound next to the FPU (or any DUT) in the checker build.

Parameters:
- NUM_CH, 6, number of compared channels
- W, 32, width of each channel (narrower signals zero-extended, mask bits set to 0)
- DEPTH, 8, golden FIFO depth (power of 2, >=2)
- CNT_W, 16, width of statistics counters
- STOP_ON_FAIL, 0, 1 = stop comparing after first mismatch until clear

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clear  in  1  synchronous soft clear of flags, counters, capture and FIFO
- ch_en  in  NUM_CH  per-channel compare enable
- gold_valid  in  1  push golden entry
- gold_data  in  NUM_CH*W  golden values, channel c at [c*W +: W]
- gold_mask  in  NUM_CH*W  1 = bit must match, 0 = don't care (unknown golden bit)
- dut_valid  in  1  DUT result present; pops one golden entry
- dut_data  in  NUM_CH*W  DUT values
- mism  out  1  one-cycle pulse: mismatch on this compare
- fail  out  1  sticky: any mismatch or protocol error
- fail_ch  out  NUM_CH  sticky per-channel mismatch
- underflow  out  1  sticky: dut_valid with FIFO empty and no same-cycle push
- overflow  out  1  sticky: push into full FIFO without same-cycle pop
- cmp_cnt  out  CNT_W  compares performed (saturating)
- mism_cnt  out  CNT_W  mismatching compares (saturating)
- ff_valid  out  1  first-failure capture valid
- ff_cycle  out  CNT_W  cycle index of first failure (saturating)
- ff_ch  out  NUM_CH  channels failing at first failure
- ff_dut / ff_gold  out  NUM_CH*W  captured DUT/golden data at first failure
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0, FIFO empty, cycle counter 0. clear has the same effect as rst; rst has priority.
- FIFO, registered:
  - Push stores gold_data and gold_mask.
  - Pop on dut_valid when occupancy>0.
  - Push and pop in the same cycle when full: legal, level unchanged.
  - Pointers wrap modulo DEPTH.
- Compare pair, bypass on empty: on dut_valid with FIFO empty and gold_valid=1, the same-cycle golden entry is used directly and is not stored. This gives a zero-latency same-cycle mode.
- Underflow: dut_valid with empty FIFO and no push sets underflow and fail; no compare, no count.
- Overflow: push when full and no pop drops the entry; sets overflow and fail.
- Compare (combinational, results registered 1 cycle after dut_valid):
  - miss[c] = ch_en[c] & |((dut[c] ^ gold[c]) & mask[c]).
  - Mismatch = |miss.
  - Channels with ch_en=0 or all-zero mask always pass.
- On each compare:
  - cmp_cnt++.
  - If mismatch: mism_cnt++, mism pulses, fail_ch |= miss, fail=1.
  - If ff_valid=0: capture ff_cycle, ff_ch=miss, ff_dut, ff_gold; set ff_valid.
  - Counters saturate at all-ones.
- Cycle counter increments every cycle after reset and saturates.
- STOP_ON_FAIL=1: once fail=1, FIFO push/pop continue but compares and counts are suppressed.
- A protocol error does capture first-failure with ff_ch=0.

Decomposition:
- Package golden_chk_pkg: helper function for channel slice extraction and the level width constant.
- One natural sub-module: golden_chk_fifo (data+mask storage, pointers, level, full/empty, bypass indication).

Test Plan:
- NUM_CH=6, W=32: push gold 0x3F800000 ch0 with full mask, dut_valid next cycle with the same data → cmp_cnt=1, mism=0, fail=0, level 1→0.
- Same, but dut ch0=0x3F800001 → mism pulse one cycle later, fail_ch=6'b000001, ff_valid=1, ff_ch=000001, ff_dut=0x3F800001, ff_gold=0x3F800000.
- Mask ch2 bit0 = 0, DUT differs only in bit0 → no mismatch. Then ch_en[3]=0 with ch3 wrong → no mismatch.
- Push 8 entries (DEPTH=8) with no pops → level=8. 9th push alone → overflow=1, fail=1, level stays 8. Push and pop in the same cycle while full → level stays 8, no overflow.
- dut_valid on empty FIFO without push → underflow=1, cmp_cnt=0. With a same-cycle push → bypass compare, cmp_cnt=1, level=0.
- STOP_ON_FAIL=1: mismatch, then 3 more matching pairs → cmp_cnt=1, mism_cnt=1. Assert clear → all flags/counters 0, FIFO empty. Assert rst while FIFO level=5 → level=0 next cycle.
